id_ex_stage: RTL

- ID/EX pipeline register of the RISC-V core, directly upstream of the ALU.
- Captures decoded operands and control, generates the 2-bit ALU `sel`, and forwards results from EX/MEM and MEM/WB onto ALU operands A/B.
- Detects load-use hazards, inserts one bubble and back-pressures decode; honours downstream stall and branch flush.

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU select, EX/MEM and MEM/WB forwarding, load-use bubble.
// Optional WB_BYPASS_EN: capture MEM/WB result when decode reads a register being written back.
module id_ex_stage #(
    parameter int Bits     = 64,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [Bits-1:0]     id_rs1_data,
    input  logic [Bits-1:0]     id_rs2_data,
    input  logic [Bits-1:0]     id_imm,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic [1:0]          id_alu_op,
    input  logic [2:0]          id_funct3,
    input  logic                id_funct7_b5,
    input  logic                id_alu_src,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_reg_write,
    input  logic                id_branch,
    input  logic                flush,
    input  logic                ex_stall,
    input  logic                exm_reg_write,
    input  logic [REG_ADDR-1:0] exm_rd,
    input  logic [Bits-1:0]     exm_result,
    input  logic                mwb_reg_write,
    input  logic [REG_ADDR-1:0] mwb_rd,
    input  logic [Bits-1:0]     mwb_result,
    output logic                ex_valid,
    output logic [Bits-1:0]     ex_A,
    output logic [Bits-1:0]     ex_B,
    output logic [1:0]          ex_sel,
    output logic [Bits-1:0]     ex_store_data,
    output logic [REG_ADDR-1:0] ex_rd,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_reg_write,
    output logic                ex_branch
);

    logic                valid_q;
    logic [REG_ADDR-1:0] rs1_q, rs2_q, rd_q;
    logic [Bits-1:0]     rs1_data_q, rs2_data_q, imm_q;
    logic [1:0]          sel_q;
    logic                alu_src_q;
    logic                mem_read_q, mem_write_q, reg_write_q, branch_q;

    logic [Bits-1:0]     rs1_data_d, rs2_data_d;
    logic [1:0]          sel_d;
    logic                load_use;
    logic [Bits-1:0]     fwd1, fwd2;

    // Loaded value needed by the next instruction is not ready yet
    assign load_use = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                      ((id_rs1 == rd_q) | (id_rs2 == rd_q));
    assign id_ready = ~ex_stall & ~load_use;

    // ALU select and capture data for the instruction now in decode
    always_comb begin
        sel_d = 2'b00;
        unique case (1'b1)
            id_alu_op == 2'b01:
                sel_d = 2'b01;
            id_alu_op == 2'b10 && id_funct3 == 3'b000:
                sel_d = {1'b0, ~id_alu_src & id_funct7_b5};
            id_alu_op == 2'b10 && id_funct3 == 3'b111:
                sel_d = 2'b10;
            id_alu_op == 2'b10 && id_funct3 == 3'b110:
                sel_d = 2'b11;
            default:
                sel_d = 2'b00;
        endcase
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
`ifdef WB_BYPASS_EN
        if (mwb_reg_write && mwb_rd != '0 && mwb_rd == id_rs1)
            rs1_data_d = mwb_result;
        if (mwb_reg_write && mwb_rd != '0 && mwb_rd == id_rs2)
            rs2_data_d = mwb_result;
`endif
    end

    // Pipeline register: flush > stall > bubble > capture > idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            sel_q       <= 2'b00;
            alu_src_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else if (!flush && ex_stall) begin
            valid_q <= valid_q;
        end else if (!flush && !load_use && id_valid) begin
            valid_q     <= 1'b1;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= id_imm;
            sel_q       <= sel_d;
            alu_src_q   <= id_alu_src;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
            reg_write_q <= id_reg_write;
            branch_q    <= id_branch;
        end else begin
            valid_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end
    end

    // Operand forwarding; EX/MEM is younger so it wins, x0 never forwards
    always_comb begin
        fwd1 = rs1_data_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs1_q)
            fwd1 = exm_result;
        else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == rs1_q)
            fwd1 = mwb_result;
        fwd2 = rs2_data_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs2_q)
            fwd2 = exm_result;
        else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == rs2_q)
            fwd2 = mwb_result;
    end

    assign ex_valid      = valid_q;
    assign ex_A          = fwd1;
    assign ex_B          = alu_src_q ? imm_q : fwd2;
    assign ex_store_data = fwd2;
    assign ex_sel        = sel_q;
    assign ex_rd         = rd_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_branch     = branch_q;

endmodule
